// File: rtl/sipo_pkg.sv
// Shared constants and types for the serial-in, parallel-out word receiver.
package sipo_pkg;

  localparam int SIPO_WIDTH = 16;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  // Width of a counter that must be able to hold the value 'width'.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Bit assembler: shift register, bit order latch, bit counter and a combinational
// completion strobe carrying the finished word.
//
// state    | meaning
// ST_IDLE  | no partial word; next valid bit is bit 0 and re-samples Left
// ST_SHIFT | 1..WIDTH-1 bits of the current word received
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Din,
  input  logic                       BitEn,
  input  logic                       Left,
  input  logic                       Start,
  output logic                       Busy,
  output logic [cnt_w(WIDTH)-1:0]    BitCnt,
  output logic                       Done,
  output logic [WIDTH-1:0]           DoneWord
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t          state, state_d, state_eff;
  logic [CW-1:0]   cnt, cnt_d, cnt_eff;
  logic [WIDTH-1:0] shreg, shreg_d, shifted;
  logic            dir_q, dir_d, dir_eff;

  // Start behaves as if the word in progress had never begun.
  always_comb begin
    state_eff = Start ? ST_IDLE : state;
    cnt_eff   = Start ? '0 : cnt;
    dir_eff   = (state_eff == ST_IDLE) ? Left : dir_q;
    shifted   = dir_eff ? {shreg[WIDTH-2:0], Din} : {Din, shreg[WIDTH-1:1]};

    state_d = state_eff;
    cnt_d   = cnt_eff;
    shreg_d = shreg;
    dir_d   = dir_q;
    Done    = 1'b0;

    if (BitEn) begin
      shreg_d = shifted;
      dir_d   = dir_eff;
      if (cnt_eff == LAST) begin
        Done    = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ST_SHIFT;
        cnt_d   = cnt_eff + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
      dir_q <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      shreg <= shreg_d;
      dir_q <= dir_d;
    end
  end

  assign DoneWord = shifted;
  assign Busy     = (state == ST_SHIFT);
  assign BitCnt   = cnt;

endmodule

// File: rtl/sipo_word_receiver.sv
// Serial word receiver: one holding register behind a valid/ready handshake,
// with a sticky overrun flag for words completed while the holder is full.
module sipo_word_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Din,
  input  logic                     BitEn,
  input  logic                     Left,
  input  logic                     Start,
  input  logic                     Ready,
  input  logic                     ClrOvr,
  output logic [WIDTH-1:0]         Word,
  output logic                     Valid,
  output logic                     Busy,
  output logic [cnt_w(WIDTH)-1:0]  BitCnt,
  output logic                     Overrun
);

  logic             done;
  logic [WIDTH-1:0] done_word;
  logic             accept;
  logic             drop;

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .Clk      (Clk),
    .Rst      (Rst),
    .Din      (Din),
    .BitEn    (BitEn),
    .Left     (Left),
    .Start    (Start),
    .Busy     (Busy),
    .BitCnt   (BitCnt),
    .Done     (done),
    .DoneWord (done_word)
  );

  // A word being consumed this cycle frees the holder for a simultaneous completion.
  assign accept = done & (~Valid | Ready);
  assign drop   = done & Valid & ~Ready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Word    <= '0;
      Valid   <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      if (accept) begin
        Word  <= done_word;
        Valid <= 1'b1;
      end else if (Valid && Ready) begin
        Valid <= 1'b0;
      end

      if (drop)
        Overrun <= 1'b1;
      else if (ClrOvr)
        Overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Directed bench for sipo_word_receiver: a queue of expected words is checked by a
// monitor at every handshake, alongside direct status checks after each scenario.
module tb_sipo_word_receiver;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Din = 1'b0;
  logic        BitEn = 1'b0;
  logic        Left = 1'b1;
  logic        Start = 1'b0;
  logic        Ready = 1'b0;
  logic        ClrOvr = 1'b0;
  logic [15:0] Word;
  logic        Valid;
  logic        Busy;
  logic [4:0]  BitCnt;
  logic        Overrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  always #5 Clk = ~Clk;

  sipo_word_receiver #(.WIDTH(16)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Din     (Din),
    .BitEn   (BitEn),
    .Left    (Left),
    .Start   (Start),
    .Ready   (Ready),
    .ClrOvr  (ClrOvr),
    .Word    (Word),
    .Valid   (Valid),
    .Busy    (Busy),
    .BitCnt  (BitCnt),
    .Overrun (Overrun)
  );

  // Monitor: every handshake must consume the oldest expected word.
  always @(negedge Clk) begin
    if (!Rst && Valid && Ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL monitor_unexpected_word actual=%h required=none", Word);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (Word !== e) begin
          n_fail++;
          $display("FAIL monitor_word actual=%h required=%h", Word, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input logic lft, input int gap,
                           input bit toggle, input bit start_first, input bit ready_last);
    for (int i = 0; i < 16; i++) begin
      if (gap > 0 && i > 0 && (i % gap) == 0) begin
        BitEn = 1'b0;
        Start = 1'b0;
        tick();
      end
      Din   = lft ? w[15-i] : w[i];
      BitEn = 1'b1;
      Left  = (toggle && i >= 5) ? ~lft : lft;
      Start = (start_first && i == 0);
      if (ready_last && i == 15) Ready = 1'b1;
      tick();
    end
    BitEn = 1'b0;
    Start = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      Din   = bits[i];
      BitEn = 1'b1;
      tick();
    end
    BitEn = 1'b0;
  endtask

  task automatic chk_word(input string name, input logic [15:0] w);
    chk({name, "_word"},   32'(Word), 32'(w));
    chk({name, "_valid"},  32'(Valid), 32'd1);
    chk({name, "_busy"},   32'(Busy), 32'd0);
    chk({name, "_bitcnt"}, 32'(BitCnt), 32'd0);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_word"},    32'(Word), 32'd0);
    chk({name, "_valid"},   32'(Valid), 32'd0);
    chk({name, "_busy"},    32'(Busy), 32'd0);
    chk({name, "_bitcnt"},  32'(BitCnt), 32'd0);
    chk({name, "_overrun"}, 32'(Overrun), 32'd0);
  endtask

  initial begin
    Rst = 1'b1;
    tick(); tick();
    Rst = 1'b0;
    chk_reset("reset");

    // MSB-first at full rate
    Ready = 1'b1;
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk_word("msb", 16'hA5C3);
    tick();
    chk("msb_consumed_valid", 32'(Valid), 32'd0);
    chk("msb_consumed_word_kept", 32'(Word), 32'hA5C3);

    // LSB-first with gaps; Left toggles mid-word and must be ignored
    exp_q.push_back(16'h1234);
    send_word(16'h1234, 1'b0, 3, 1'b1, 1'b0, 1'b0);
    chk_word("lsb_gaps", 16'h1234);
    tick();

    // Backpressure and overrun
    Ready = 1'b0;
    send_word(16'h00FF, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("bp_first_valid", 32'(Valid), 32'd1);
    chk("bp_first_overrun", 32'(Overrun), 32'd0);
    send_word(16'hFF00, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("bp_word_held", 32'(Word), 32'h00FF);
    chk("bp_overrun_set", 32'(Overrun), 32'd1);
    tick();
    chk("bp_overrun_sticky", 32'(Overrun), 32'd1);
    ClrOvr = 1'b1;
    tick();
    ClrOvr = 1'b0;
    chk("bp_overrun_cleared", 32'(Overrun), 32'd0);
    exp_q.push_back(16'h00FF);
    Ready = 1'b1;
    tick();
    chk("bp_drained_valid", 32'(Valid), 32'd0);

    // Completion coinciding with consumption of the held word
    Ready = 1'b0;
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    send_word(16'h1111, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    send_word(16'h2222, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    chk_word("simul", 16'h2222);
    chk("simul_overrun", 32'(Overrun), 32'd0);
    tick();
    chk("simul_drained_valid", 32'(Valid), 32'd0);

    // Resync after garbage bits
    Left = 1'b0;
    send_bits(16'b0000_0000_0100_1101, 7);
    chk("resync_busy", 32'(Busy), 32'd1);
    chk("resync_bitcnt", 32'(BitCnt), 32'd7);
    exp_q.push_back(16'hBEEF);
    send_word(16'hBEEF, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    chk_word("resync", 16'hBEEF);
    tick();

    // Reset mid-word with a held word and overrun pending
    Ready = 1'b0;
    send_word(16'h5A5A, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    send_word(16'h0F0F, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("rst_pre_overrun", 32'(Overrun), 32'd1);
    send_bits(16'h01B5, 9);
    chk("rst_pre_bitcnt", 32'(BitCnt), 32'd9);
    chk("rst_pre_valid", 32'(Valid), 32'd1);
    Rst   = 1'b1;
    BitEn = 1'b1;
    Din   = 1'b1;
    tick();
    Rst   = 1'b0;
    BitEn = 1'b0;
    chk_reset("rst_mid");
    Ready = 1'b1;
    exp_q.push_back(16'hCAFE);
    send_word(16'hCAFE, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk_word("after_rst", 16'hCAFE);
    tick();
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_word_receiver.md
# sipo_word_receiver

Serial-in, parallel-out receiver that reassembles 16-bit words from the single-bit stream produced by the team's SISO shift-register transmitter. It sits at the far end of the serial link and supports the same MSB-first (Left) and LSB-first bit orders. It double-buffers one completed word behind a valid/ready handshake and flags overruns.

## Interface

- WIDTH, 16, word length in bits (≥2)
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous, active-high reset
- Din  input  1  serial data bit
- BitEn  input  1  Din carries a valid bit this cycle
- Left  input  1  1 = MSB-first word, 0 = LSB-first; sampled on the first bit of each word
- Start  input  1  frame resync: discard partial word; if BitEn also high, this bit is bit 0 of a new word
- Ready  input  1  downstream accepts Word this cycle
- ClrOvr  input  1  clears Overrun
- Word  output  WIDTH  assembled word (holding register)
- Valid  output  1  Word holds an unconsumed word
- Busy  output  1  a partial word is in progress
- BitCnt  output  clog2(WIDTH+1)  bits received in current word
- Overrun  output  1  sticky: a completed word was dropped

## Operation

- States: IDLE (no partial word), SHIFT (1..WIDTH-1 bits received).
- IDLE + BitEn: latch Left into dir_q, shift Din in, BitCnt=1, go SHIFT.
- SHIFT + BitEn: shift Din in, BitCnt+1. When the WIDTH-th bit arrives: word complete, BitCnt→0, go IDLE.
- Shift rule, dir_q=1: shreg <= {shreg[WIDTH-2:0], Din} (first bit lands at MSB). dir_q=0: shreg <= {Din, shreg[WIDTH-1:1]} (first bit lands at LSB).
- Left changes mid-word are ignored; only the first-bit sample counts.
- BitEn low: no shift, state and count hold (gaps allowed anywhere).
- Start: BitCnt→0, partial bits discarded, state IDLE; with BitEn in same cycle, behaves as IDLE+BitEn (Left re-sampled). Start never affects Word/Valid.
- Completion transfer: if Valid=0, or Valid=1 and Ready=1 in the same cycle, Word <= completed word, Valid=1.
- Completion with Valid=1 and Ready=0: completed word dropped, Word unchanged, Overrun=1.
- Ready with Valid=1 and no completion: Valid→0; Word retains last value.
- Ready with Valid=0: no effect.
- ClrOvr clears Overrun; a new overrun in the same cycle wins (Overrun stays 1).
- Busy = (state==SHIFT).

## Timing

- Reset values: Word=0, Valid=0, Busy=0, BitCnt=0, Overrun=0, state IDLE, shreg=0, dir_q=1.
- Rst mid-word: partial word and held word discarded; all outputs to reset values next edge; Rst overrides all other inputs.
- All outputs registered. Valid rises on the edge that samples the WIDTH-th bit (word visible the cycle after last BitEn).
- Handshake completes on any edge with Valid&Ready; back-to-back words at full rate (BitEn held high, Ready high) sustain one word per WIDTH cycles with no bubbles.
- Minimum spacing between completions is WIDTH cycles, so one holding register suffices when Ready responds within WIDTH-1 cycles.

## Structure

- Package sipo_pkg: state enum (IDLE, SHIFT), default WIDTH constant, BitCnt width function/constant.
- One natural sub-module: sipo_shift_core (shreg, dir_q, bit counter, completion pulse); top handles holding register, handshake, Overrun.
- Estimated 150-250 lines RTL.

## Test plan

- MSB-first: Left=1, BitEn=1 for 16 cycles with bits of 0xA5C3 MSB first -> Valid=1 next cycle, Word=0xA5C3, Busy=0, BitCnt=0.
- LSB-first with gaps: Left=0, send 0x1234 LSB first with BitEn low every third cycle, Left toggled after bit 5 -> Word=0x1234.
- Backpressure: Ready=0, send 0x00FF then 0xFF00 -> Word=0x00FF, Overrun=1; ClrOvr -> Overrun=0; Ready -> Valid=0.
- Simultaneous: Valid=1 (0x1111), Ready=1 on the completion cycle of 0x2222 -> Word=0x2222, Valid stays 1, Overrun=0.
- Resync: 7 bits of garbage, then Start+BitEn with first bit of 0xBEEF -> Word=0xBEEF after 16 bits total from Start.
- Reset mid-word: Rst after 9 bits with Valid=1 -> all outputs 0 next cycle; then full 0xCAFE received correctly.
